// File: rtl/sprite_mover_pkg.sv
// Shared types, keycodes and the per-axis key decode for the sprite mover.
package sprite_pkg;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mover_state_t;

  typedef logic signed [1:0] axis_dir_t;

  localparam axis_dir_t AXIS_NEG  = 2'sb11;
  localparam axis_dir_t AXIS_ZERO = 2'sb00;
  localparam axis_dir_t AXIS_POS  = 2'sb01;

  // Opposing keys cancel; a code present on both inputs still counts once.
  function automatic axis_dir_t decode_axis(input logic [7:0] k0, input logic [7:0] k1,
                                            input logic [7:0] neg_key, input logic [7:0] pos_key);
    logic neg, pos;
    neg = (k0 == neg_key) || (k1 == neg_key);
    pos = (k0 == pos_key) || (k1 == pos_key);
    if (neg && !pos) return AXIS_NEG;
    if (pos && !neg) return AXIS_POS;
    return AXIS_ZERO;
  endfunction

endpackage

// File: rtl/sprite_mover_axis_stepper.sv
// One axis of sprite motion: step, then clamp (default) or wrap (SPRITE_WRAP_EN).
module axis_stepper
  import sprite_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int MIN     = 0,
  parameter int MAX     = 479,
  parameter int SIZE    = 10,
  parameter int STEP    = 1
) (
  input  logic [COORD_W-1:0] pos,
  input  axis_dir_t          dir,
  input  logic               tick,
  output logic [COORD_W-1:0] next_pos,
  output logic               lo,
  output logic               hi
);

  localparam int W = COORD_W + 2;
  localparam logic signed [W-1:0] LIM_LO = W'(MIN + SIZE);
  localparam logic signed [W-1:0] LIM_HI = W'(MAX - SIZE);
  localparam logic signed [W-1:0] STEP_S = W'(STEP);
`ifdef SPRITE_WRAP_EN
  localparam logic signed [W-1:0] ONE_S  = W'(1);
`endif

  logic signed [W-1:0] cand;
  logic signed [W-1:0] bounded;

  always_comb begin
    cand = $signed({2'b00, pos});
    if (dir == AXIS_POS)      cand = cand + STEP_S;
    else if (dir == AXIS_NEG) cand = cand - STEP_S;

    bounded = cand;
`ifdef SPRITE_WRAP_EN
    // Overshoot of k pixels re-enters k-1 pixels inside the opposite limit.
    if (cand > LIM_HI)      bounded = LIM_LO + (cand - LIM_HI - ONE_S);
    else if (cand < LIM_LO) bounded = LIM_HI - (LIM_LO - cand - ONE_S);
`else
    if (cand > LIM_HI)      bounded = LIM_HI;
    else if (cand < LIM_LO) bounded = LIM_LO;
`endif

    next_pos = tick ? COORD_W'(bounded) : pos;
  end

`ifdef SPRITE_WRAP_EN
  assign lo = 1'b0;
  assign hi = 1'b0;
`else
  assign lo = (next_pos == COORD_W'(MIN + SIZE));
  assign hi = (next_pos == COORD_W'(MAX - SIZE));
`endif

endmodule

// File: rtl/sprite_mover.sv
// Keyboard-driven sprite position generator on the VGA frame clock.
// Optional wrap-around playfield enabled by defining SPRITE_WRAP_EN.
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int COORD_W   = 10,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 479,
  parameter int Y_MIN     = 0,
  parameter int Y_MAX     = 479,
  parameter int X_START   = 320,
  parameter int Y_START   = 240,
  parameter int SIZE      = 10,
  parameter int STEP      = 1,
  parameter int FRAME_DIV = 1
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic [7:0]         keycode0,
  input  logic [7:0]         keycode1,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [COORD_W-1:0] size,
  output logic [1:0]         facing,
  output logic               moving,
  output logic [3:0]         at_edge
);

  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);
`ifdef SPRITE_WRAP_EN
  localparam logic [3:0] EDGE_RST = 4'b0000;
`else
  localparam logic [3:0] EDGE_RST = {Y_START == Y_MIN + SIZE, Y_START == Y_MAX - SIZE,
                                     X_START == X_MIN + SIZE, X_START == X_MAX - SIZE};
`endif

  generate
    if (X_START < X_MIN + SIZE || X_START > X_MAX - SIZE ||
        Y_START < Y_MIN + SIZE || Y_START > Y_MAX - SIZE ||
        STEP < 1 || STEP > SIZE || FRAME_DIV < 1 || FRAME_DIV > 255) begin : g_bad_params
      $error("sprite_mover: illegal parameter combination");
    end
  endgenerate

  axis_dir_t          dx, dy;
  logic               active, tick, moving_next;
  mover_state_t       state, state_next;
  logic [7:0]         divider, divider_next, cur_div;
  dir_t               facing_q, facing_next;
  logic [COORD_W-1:0] next_x, next_y;
  logic               x_lo, x_hi, y_lo, y_hi;

  assign dx     = decode_axis(keycode0, keycode1, KEY_A, KEY_D);
  assign dy     = decode_axis(keycode0, keycode1, KEY_W, KEY_S);
  assign active = (dx != AXIS_ZERO) || (dy != AXIS_ZERO);

  always_comb begin
    state_next   = IDLE;
    divider_next = '0;
    tick         = 1'b0;
    facing_next  = facing_q;
    // Counting always restarts from zero on the first edge out of IDLE.
    cur_div      = (state == RUN) ? divider : '0;

    if (active) begin
      state_next = RUN;
      if (cur_div == DIV_LAST) tick = 1'b1;
      else                     divider_next = cur_div + 8'd1;
    end

    if (dx != AXIS_ZERO)      facing_next = (dx == AXIS_NEG) ? LEFT : RIGHT;
    else if (dy != AXIS_ZERO) facing_next = (dy == AXIS_NEG) ? UP : DOWN;
  end

  axis_stepper #(
    .COORD_W(COORD_W), .MIN(X_MIN), .MAX(X_MAX), .SIZE(SIZE), .STEP(STEP)
  ) u_step_x (
    .pos(pos_x), .dir(dx), .tick(tick), .next_pos(next_x), .lo(x_lo), .hi(x_hi)
  );

  axis_stepper #(
    .COORD_W(COORD_W), .MIN(Y_MIN), .MAX(Y_MAX), .SIZE(SIZE), .STEP(STEP)
  ) u_step_y (
    .pos(pos_y), .dir(dy), .tick(tick), .next_pos(next_y), .lo(y_lo), .hi(y_hi)
  );

  assign moving_next = (next_x != pos_x) || (next_y != pos_y);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      divider  <= '0;
      pos_x    <= COORD_W'(X_START);
      pos_y    <= COORD_W'(Y_START);
      facing_q <= RIGHT;
      moving   <= 1'b0;
      at_edge  <= EDGE_RST;
    end else begin
      state    <= state_next;
      divider  <= divider_next;
      pos_x    <= next_x;
      pos_y    <= next_y;
      facing_q <= facing_next;
      moving   <= moving_next;
      at_edge  <= {y_lo, y_hi, x_lo, x_hi};
    end
  end

  assign facing = facing_q;
  assign size   = COORD_W'(SIZE);

endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover: three parameterisations driven by shared keys, checked against a model.
module tb_sprite_mover;

  localparam int LO = 10;
  localparam int HI = 469;
  localparam logic [7:0] K_W = 8'h1A, K_A = 8'h04, K_S = 8'h16, K_D = 8'h07;

  logic       frame_clk, Reset;
  logic [7:0] keycode0, keycode1;
  logic [9:0] px[3], py[3], sz[3];
  logic [1:0] fc[3];
  logic       mv[3];
  logic [3:0] ae[3];

  int errors = 0;
  int checks = 0;

  int m_step[3] = '{1, 3, 1};
  int m_div[3]  = '{1, 1, 4};
  int mx[3], my[3], mf[3], mcnt[3];
  bit mmov[3];

  sprite_mover dut_a (
    .frame_clk(frame_clk), .Reset(Reset), .keycode0(keycode0), .keycode1(keycode1),
    .pos_x(px[0]), .pos_y(py[0]), .size(sz[0]), .facing(fc[0]), .moving(mv[0]), .at_edge(ae[0])
  );
  sprite_mover #(.STEP(3)) dut_b (
    .frame_clk(frame_clk), .Reset(Reset), .keycode0(keycode0), .keycode1(keycode1),
    .pos_x(px[1]), .pos_y(py[1]), .size(sz[1]), .facing(fc[1]), .moving(mv[1]), .at_edge(ae[1])
  );
  sprite_mover #(.FRAME_DIV(4)) dut_c (
    .frame_clk(frame_clk), .Reset(Reset), .keycode0(keycode0), .keycode1(keycode1),
    .pos_x(px[2]), .pos_y(py[2]), .size(sz[2]), .facing(fc[2]), .moving(mv[2]), .at_edge(ae[2])
  );

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  // ---------------- reference model ----------------
  function automatic int key_axis(input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] neg, input logic [7:0] pos);
    int v = 0;
    if (a == pos || b == pos) v += 1;
    if (a == neg || b == neg) v -= 1;
    return v;
  endfunction

  function automatic int move_axis(input int p, input int d, input int step);
    int n = p + d * step;
`ifdef SPRITE_WRAP_EN
    if (n > HI)      n = LO + (n - HI - 1);
    else if (n < LO) n = HI - (LO - n - 1);
`else
    if (n > HI)      n = HI;
    else if (n < LO) n = LO;
`endif
    return n;
  endfunction

  function automatic logic [3:0] exp_edge(input int x, input int y);
`ifdef SPRITE_WRAP_EN
    return 4'b0000;
`else
    return {y == LO, y == HI, x == LO, x == HI};
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mx[i] = 320; my[i] = 240; mf[i] = 3; mcnt[i] = 0; mmov[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [7:0] a, input logic [7:0] b);
    int dx, dy, nx, ny;
    dx = key_axis(a, b, K_A, K_D);
    dy = key_axis(a, b, K_W, K_S);
    for (int i = 0; i < 3; i++) begin
      mmov[i] = 1'b0;
      if (dx == 0 && dy == 0) begin
        mcnt[i] = 0;
      end else begin
        if (dx != 0) mf[i] = (dx < 0) ? 2 : 3;
        else         mf[i] = (dy < 0) ? 0 : 1;
        mcnt[i]++;
        if (mcnt[i] == m_div[i]) begin
          mcnt[i] = 0;
          nx = move_axis(mx[i], dx, m_step[i]);
          ny = move_axis(my[i], dy, m_step[i]);
          mmov[i] = (nx != mx[i]) || (ny != my[i]);
          mx[i] = nx;
          my[i] = ny;
        end
      end
    end
  endtask

  task automatic step(input logic [7:0] a, input logic [7:0] b);
    keycode0 = a;
    keycode1 = b;
    @(posedge frame_clk);
    model_edge(a, b);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #2;
    model_reset();
    Reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    Reset = 1'b0; keycode0 = 8'h00; keycode1 = 8'h00;
    #1 Reset = 1'b1;
    model_reset();
    #2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({px[i], py[i], sz[i], fc[i], mv[i], ae[i]} !== {10'd320, 10'd240, 10'd10, 2'd3, 1'b0, 4'b0000}) begin
        errors++;
        $display("FAIL reset dut%0d: got x=%0d y=%0d size=%0d f=%0d mv=%0b e=%b, need 320 240 10 3 0 0000",
                 i, px[i], py[i], sz[i], fc[i], mv[i], ae[i]);
      end
    end
    #1 Reset = 1'b0;
  endtask

  task automatic test_walk_right();
    for (int e = 1; e <= 5; e++) begin
      step(K_D, 8'h00);
      checks++;
      if (px[0] !== 10'(320 + e) || py[0] !== 10'd240 || mv[0] !== 1'b1) begin
        errors++;
        $display("FAIL walk_right edge %0d: got x=%0d y=%0d mv=%0b, need x=%0d y=240 mv=1",
                 e, px[0], py[0], mv[0], 320 + e);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({px[i], py[i], fc[i], mv[i], ae[i]} !== {10'(mx[i]), 10'(my[i]), 2'(mf[i]), mmov[i], exp_edge(mx[i], my[i])}) begin
          errors++;
          $display("FAIL walk_right_model dut%0d: got x=%0d y=%0d f=%0d mv=%0b e=%b, need x=%0d y=%0d f=%0d mv=%0b e=%b",
                   i, px[i], py[i], fc[i], mv[i], ae[i], mx[i], my[i], mf[i], mmov[i], exp_edge(mx[i], my[i]));
        end
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int e = 0; e < 200; e++) begin
      step(K_D, 8'h00);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({px[i], py[i], fc[i], mv[i], ae[i]} !== {10'(mx[i]), 10'(my[i]), 2'(mf[i]), mmov[i], exp_edge(mx[i], my[i])}) begin
          errors++;
          $display("FAIL saturate_model dut%0d edge %0d: got x=%0d y=%0d mv=%0b e=%b, need x=%0d y=%0d mv=%0b e=%b",
                   i, e, px[i], py[i], mv[i], ae[i], mx[i], my[i], mmov[i], exp_edge(mx[i], my[i]));
        end
      end
    end
`ifndef SPRITE_WRAP_EN
    checks++;
    if (px[1] !== 10'd469 || ae[1] !== 4'b0001 || mv[1] !== 1'b0) begin
      errors++;
      $display("FAIL saturate_wall: got x=%0d e=%b mv=%0b, need x=469 e=0001 mv=0", px[1], ae[1], mv[1]);
    end
`endif
  endtask

  task automatic test_diagonal_cancel();
    do_reset();
    for (int e = 0; e < 4; e++) step(K_W, K_A);
    checks++;
    if (px[0] !== 10'd316 || py[0] !== 10'd236 || fc[0] !== 2'd2) begin
      errors++;
      $display("FAIL diagonal: got x=%0d y=%0d f=%0d, need 316 236 2", px[0], py[0], fc[0]);
    end
    for (int e = 0; e < 3; e++) begin
      step(K_A, K_D);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({px[i], py[i], fc[i], mv[i], ae[i]} !== {10'(mx[i]), 10'(my[i]), 2'(mf[i]), mmov[i], exp_edge(mx[i], my[i])}) begin
          errors++;
          $display("FAIL cancel_model dut%0d: got x=%0d y=%0d f=%0d mv=%0b, need x=%0d y=%0d f=%0d mv=%0b",
                   i, px[i], py[i], fc[i], mv[i], mx[i], my[i], mf[i], mmov[i]);
        end
      end
    end
    checks++;
    if (px[0] !== 10'd316 || py[0] !== 10'd236 || mv[0] !== 1'b0 || fc[0] !== 2'd2) begin
      errors++;
      $display("FAIL cancel_frozen: got x=%0d y=%0d mv=%0b f=%0d, need 316 236 0 2", px[0], py[0], mv[0], fc[0]);
    end
  endtask

  task automatic test_frame_div();
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      step(K_D, 8'h00);
      checks++;
      if (px[2] !== 10'(320 + e / 4) || mv[2] !== (e % 4 == 0)) begin
        errors++;
        $display("FAIL frame_div edge %0d: got x=%0d mv=%0b, need x=%0d mv=%0b", e, px[2], mv[2], 320 + e / 4, e % 4 == 0);
      end
    end
    do_reset();
    step(K_D, 8'h00);
    step(K_D, 8'h00);
    step(8'h00, 8'h00);
    for (int e = 1; e <= 4; e++) begin
      step(8'h00, K_D);
      checks++;
      if (px[2] !== 10'(320 + e / 4)) begin
        errors++;
        $display("FAIL frame_div_restart edge %0d: got x=%0d, need x=%0d", e, px[2], 320 + e / 4);
      end
    end
  endtask

  task automatic test_bound_tick();
    do_reset();
    for (int e = 0; e < 149; e++) step(K_D, 8'h00);
    checks++;
    if (px[0] !== 10'd469 || ae[0] !== 4'b0001 && exp_edge(469, 240) == 4'b0001) begin
      errors++;
      $display("FAIL bound_arrive: got x=%0d e=%b, need x=469 e=%b", px[0], ae[0], exp_edge(469, 240));
    end
    step(K_D, 8'h00);
    checks++;
`ifdef SPRITE_WRAP_EN
    if (px[0] !== 10'd10 || ae[0] !== 4'b0000 || mv[0] !== 1'b1) begin
      errors++;
      $display("FAIL bound_tick: got x=%0d e=%b mv=%0b, need x=10 e=0000 mv=1", px[0], ae[0], mv[0]);
    end
`else
    if (px[0] !== 10'd469 || ae[0] !== 4'b0001 || mv[0] !== 1'b0) begin
      errors++;
      $display("FAIL bound_tick: got x=%0d e=%b mv=%0b, need x=469 e=0001 mv=0", px[0], ae[0], mv[0]);
    end
`endif
  endtask

  task automatic test_reset_mid_motion();
    do_reset();
    for (int e = 0; e < 3; e++) step(K_S, K_A);
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (px[0] !== 10'd320 || py[0] !== 10'd240 || fc[0] !== 2'd3 || mv[0] !== 1'b0 || ae[0] !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_motion: got x=%0d y=%0d f=%0d mv=%0b e=%b, need 320 240 3 0 0000",
               px[0], py[0], fc[0], mv[0], ae[0]);
    end
    model_reset();
    Reset = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] pool[7];
    logic [7:0] a, b;
    int len;
    pool = '{8'h00, K_A, K_D, K_W, K_S, 8'h2C, 8'h05};
    do_reset();
    for (int s = 0; s < 50; s++) begin
      a = pool[$urandom_range(0, 6)];
      b = pool[$urandom_range(0, 6)];
      if ($urandom_range(0, 7) == 0) a = 8'($urandom);
      len = $urandom_range(1, 30);
      for (int e = 0; e < len; e++) begin
        step(a, b);
        for (int i = 0; i < 3; i++) begin
          checks++;
          if ({px[i], py[i], fc[i], mv[i], ae[i]} !== {10'(mx[i]), 10'(my[i]), 2'(mf[i]), mmov[i], exp_edge(mx[i], my[i])}) begin
            errors++;
            $display("FAIL random dut%0d keys %h/%h: got x=%0d y=%0d f=%0d mv=%0b e=%b, need x=%0d y=%0d f=%0d mv=%0b e=%b",
                     i, a, b, px[i], py[i], fc[i], mv[i], ae[i], mx[i], my[i], mf[i], mmov[i], exp_edge(mx[i], my[i]));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_walk_right();
    test_saturate();
    test_diagonal_cancel();
    test_frame_div();
    test_bound_tick();
    test_reset_mid_motion();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_mover.md
Name: sprite_mover

Overview:
Parametrised keyboard-driven sprite position generator, the successor to the single-ball mover. It takes two simultaneous USB keycodes (WASD), supports diagonal motion, a configurable step size and a frame-rate divider, and clamps the sprite exactly at the bounds. It runs on the VGA frame clock and feeds the colour mapper and collision logic with position, size, facing and edge flags.

Parameters:
COORD_W, 10, width of position outputs (unsigned)
X_MIN, 0, leftmost playfield coordinate
X_MAX, 479, rightmost playfield coordinate
Y_MIN, 0, topmost playfield coordinate
Y_MAX, 479, bottommost playfield coordinate
X_START, 320, reset X (centre of sprite)
Y_START, 240, reset Y (centre of sprite)
SIZE, 10, sprite half-extent
STEP, 1, pixels moved per move tick, range 1..SIZE
FRAME_DIV, 1, frames per move tick, range 1..255

Ports:
frame_clk  input  1  frame clock, one rising edge per VGA frame
Reset  input  1  asynchronous, active-high reset
keycode0  input  8  first held keycode, 0x00 = none
keycode1  input  8  second held keycode, 0x00 = none
pos_x  output  COORD_W  sprite centre X
pos_y  output  COORD_W  sprite centre Y
size  output  COORD_W  constant SIZE
facing  output  2  last non-zero direction: 0=up 1=down 2=left 3=right
moving  output  1  high in a cycle where position changed
at_edge  output  4  {up,down,left,right}; bit set when sprite touches that bound

Behaviour:
- Reset is asynchronous: pos_x=X_START, pos_y=Y_START, facing=3, moving=0, at_edge recomputed from the reset position (0 for the defaults), divider=0, state=IDLE.
- Key decode is combinational and per axis, over both keycode inputs. Keycodes: 0x04 A gives dx=-1, 0x07 D gives dx=+1, 0x1A W gives dy=-1, 0x16 S gives dy=+1.
- Opposing keys on the same axis cancel, giving 0 on that axis. Unknown codes are ignored. A duplicate code on both inputs counts once.
- FSM states:
  - IDLE: taken when dx=dy=0. Divider is held at 0 and moving=0.
  - RUN: taken when any axis is non-zero. Divider counts 0..FRAME_DIV-1. The move tick fires on the edge where divider==FRAME_DIV-1, and the divider then wraps to 0.
  - With FRAME_DIV=1, every frame edge with a key held is a tick. The first move happens FRAME_DIV edges after the key is first seen.
- On a tick, each axis computes the candidate position in COORD_W+2-bit signed arithmetic using the current cycle's direction. No stale motion register is used.
  - Clamp: the result is limited to [MIN+SIZE, MAX-SIZE]. A step that would overshoot lands exactly on the limit.
- moving=1 only if pos_x or pos_y actually changed on this edge. Holding into a wall gives moving=0.
- facing updates on every edge with a non-zero direction:
  - the horizontal direction wins on a diagonal;
  - it holds its value in IDLE.
- at_edge is registered from the new position. Example: left bit = (pos_x == X_MIN+SIZE).
- Both axes update on the same edge, so diagonal motion is STEP in X and STEP in Y.
- Key released mid-divide: go to IDLE and clear the divider, so no partial tick carries over.
- Reset mid-motion overrides everything immediately.
- Elaboration check: X_MIN+SIZE <= X_START <= X_MAX-SIZE (same for Y), and 1 <= STEP <= SIZE.

Optional Feature:
SPRITE_WRAP_EN
- Defined: a move past a bound re-enters from the opposite side. Past the max, the position becomes MIN+SIZE + (overshoot-1); past the min, it mirrors that. In this mode at_edge is always 0 and moving=1 on every tick with a key held.
- Undefined: clamp behaviour exactly as described above.

Decomposition:
- Package sprite_pkg holds:
  - keycode constants KEY_W/KEY_A/KEY_S/KEY_D;
  - typedef enum dir_t (UP, DOWN, LEFT, RIGHT) for facing;
  - typedef enum mover_state_t (IDLE, RUN);
  - typedef logic signed [1:0] axis_dir_t.
- Sub-module axis_stepper, instantiated once per axis with MIN/MAX/SIZE/STEP. It takes the current position, direction and tick, and returns the next position plus lo/hi edge flags, with the clamp/wrap selected by the macro.
- The top level holds the decode, FSM, divider, facing and registers.

Test Plan:
- Reset pulse mid-frame with defaults -> pos=(320,240), facing=3, moving=0, at_edge=0000 with no clock edge needed.
- keycode0=0x07 held for 5 edges, FRAME_DIV=1, STEP=1 -> pos_x=325, pos_y=240, moving=1 on each edge.
- keycode0=0x07 held for 200 edges, STEP=3 -> pos_x saturates at 469 exactly, at_edge=0001, moving=0 after arrival.
- keycode0=0x1A, keycode1=0x04 for 4 edges -> pos=(316,236), facing=2. Then keycode0=0x04, keycode1=0x07 -> position frozen, state IDLE.
- FRAME_DIV=4, D held 12 edges -> pos_x changes only on edges 4, 8, 12 (final 323). Releasing the key after 2 edges and re-pressing restarts the count.
- SPRITE_WRAP_EN, X at 469, D held one tick with STEP=1 -> pos_x=10, at_edge=0000.
